// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: next-PC select codes and the select priority rule.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package fetch_sequencer_pkg;

    // Next-PC select codes understood by the PC unit (PcApparatus).
    localparam logic [1:0] PCSEL_PCPLUSFOUR = 2'd0;
    localparam logic [1:0] PCSEL_PCOFFSET   = 2'd1;
    localparam logic [1:0] PCSEL_REGOFFSET  = 2'd2;

    // Default widths shared by the interface and the top level.
    localparam int DBITS_DEFAULT    = 32;
    localparam int CNT_BITS_DEFAULT = 32;

    // Next-PC source for a retiring instruction. JAL wins over a taken branch;
    // everything else falls through to pc + 4.
    function automatic logic [1:0] pick_pc_sel(
        input logic is_jal,
        input logic is_branch,
        input logic cmp
    );
        logic [1:0] sel;
        sel = PCSEL_PCPLUSFOUR;
        if (is_jal) begin
            sel = PCSEL_REGOFFSET;
        end else if (is_branch && cmp) begin
            sel = PCSEL_PCOFFSET;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the PC-unit, instruction-memory and decode/execute signals around the fetch sequencer.
// Latency: n/a (wires only).
// Backpressure: imem_ready throttles fetch requests; ex_done holds the current instruction.
interface fetch_sequencer_if #(
    parameter int DBITS = 32
);
    // PC unit
    logic [DBITS-1:0] pc;
    logic [1:0]       pc_sel;
    logic             pc_we;

    // Instruction memory
    logic             imem_req;
    logic [DBITS-1:0] imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [DBITS-1:0] imem_rdata;

    // Decode / execute datapath
    logic [DBITS-1:0] instr;
    logic             instr_valid;
    logic             is_branch;
    logic             is_jal;
    logic             cmp;
    logic             halt;
    logic             ex_done;

    // Sequencer side
    modport master (
        input  pc,
        output pc_sel,
        output pc_we,
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  is_branch,
        input  is_jal,
        input  cmp,
        input  halt,
        input  ex_done
    );

    // Surrounding PC unit / imem / datapath side
    modport slave (
        output pc,
        input  pc_sel,
        input  pc_we,
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output is_branch,
        output is_jal,
        output cmp,
        output halt,
        output ex_done
    );

endinterface

// File: rtl/fetch_perf_counter.sv
// Retired-instruction and imem-stall counters for the fetch sequencer (built only with FETCH_SEQ_PERF_CNT_EN).
// Latency: counts appear on the outputs one cycle after the qualifying event.
// Backpressure: none; counts every qualifying cycle and wraps modulo 2^CNT_BITS.
`ifdef FETCH_SEQ_PERF_CNT_EN
module fetch_perf_counter #(
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                retire_inc,
    input  logic                stall_inc,
    output logic [CNT_BITS-1:0] retired_cnt,
    output logic [CNT_BITS-1:0] stall_cnt
);

    // Free-running wrap-around counters; the sequencer gates the increments.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire_inc) begin
                retired_cnt <= retired_cnt + CNT_BITS'(1);
            end
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_BITS'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetches at pc, holds the instruction until execute completes, then strobes the PC update.
// Latency: 3 cycles per instruction minimum (request accepted, response, execute done); pc_we is combinational in the retiring cycle.
// Backpressure: stalls in fetch while !imem_ready, in wait while !imem_rvalid, in exec while !ex_done. Optional counters: FETCH_SEQ_PERF_CNT_EN.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int DBITS    = DBITS_DEFAULT,
    parameter int CNT_BITS = CNT_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    fetch_sequencer_if.master   bus,
    output logic                halted,
    output logic [CNT_BITS-1:0] retired_cnt,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           state;
    logic [DBITS-1:0] instr_q;
    logic             instr_valid_q;
    logic             halted_q;
    logic             retire;

    // Instruction retires in the exec cycle where the datapath reports completion.
    assign retire = (state == S_EXEC) && bus.ex_done;

    // Sequencer state plus the registered instruction/valid/halted outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_FETCH;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        instr_q       <= bus.imem_rdata;
                        instr_valid_q <= 1'b1;
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.ex_done) begin
                        instr_valid_q <= 1'b0;
                        if (bus.halt) begin
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    // Only reset leaves halt.
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Request, PC strobe and next-PC select decoded from the current state.
    always_comb begin
        bus.imem_req  = (state == S_FETCH);
        bus.imem_addr = bus.pc;
        bus.pc_we     = retire;
        bus.pc_sel    = PCSEL_PCPLUSFOUR;
        if (retire) begin
            bus.pc_sel = pick_pc_sel(bus.is_jal, bus.is_branch, bus.cmp);
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign halted          = halted_q;

`ifdef FETCH_SEQ_PERF_CNT_EN
    logic stall;

    // A stall is a fetch cycle refused by imem or a wait cycle with no response yet.
    assign stall = ((state == S_FETCH) && !bus.imem_ready) ||
                   ((state == S_WAIT)  && !bus.imem_rvalid);

    fetch_perf_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .retire_inc  (retire),
        .stall_inc   (stall),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: an open-loop environment plays imem/datapath timing, a monitor checks fetches and retires.
// Latency: each expected event carries the cycle in which it must appear.
// Backpressure: imem_ready, imem_rvalid and ex_done delays are randomized per instruction.
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
    } fetch_exp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] instr;
        logic [1:0]  sel;
    } retire_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        halted;
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;

    fetch_sequencer_if #(.DBITS(32)) bus ();

    fetch_sequencer #(
        .DBITS    (32),
        .CNT_BITS (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .halted      (halted),
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;
    int          exp_retired = 0;
    bit          mon_en = 1'b0;
    fetch_exp_t  fq[$];
    retire_exp_t rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Counter value the build should show: the event count, or 0 when counters are compiled out.
    function automatic logic [31:0] exp_cnt(input int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    // Reference next-PC rule: JAL -> 2, taken branch -> 1, otherwise 0.
    function automatic logic [1:0] model_sel(input logic jal, input logic br, input logic c);
        if (jal) return 2'd2;
        if (br && c) return 2'd1;
        return 2'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_decode();
        bus.is_jal    = 1'($urandom);
        bus.is_branch = 1'($urandom);
        bus.cmp       = 1'($urandom);
        bus.halt      = 1'($urandom);
    endtask

    // Monitor: every accepted fetch and every PC strobe must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.imem_req && bus.imem_ready) begin
                if (fq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_unexpected: addr %h at cycle %0d, none expected", bus.imem_addr, cyc);
                end else begin
                    fetch_exp_t f;
                    f = fq.pop_front();
                    chk("fetch_cycle", 32'(cyc), f.cyc);
                    chk("fetch_addr", bus.imem_addr, f.addr);
                end
            end
            if (bus.pc_we) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pc_we_unexpected: pc_sel %0d at cycle %0d, none expected", bus.pc_sel, cyc);
                end else begin
                    retire_exp_t r;
                    r = rq.pop_front();
                    chk("retire_cycle", 32'(cyc), r.cyc);
                    chk("retire_instr", bus.instr, r.instr);
                    chk("retire_valid", 32'(bus.instr_valid), 32'd1);
                    chk("retire_pc_sel", 32'(bus.pc_sel), 32'(r.sel));
                end
            end else begin
                chk("idle_pc_sel", 32'(bus.pc_sel), 32'd0);
            end
        end
    end

    // Reset for two cycles, then check the reset state in the first released cycle.
    task automatic do_reset();
        reset           = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.ex_done     = 1'b0;
        tick();
        tick();
        reset       = 1'b0;
        exp_stall   = 0;
        exp_retired = 0;
        #1;
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd1);
        chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
        chk("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("rst_retired_cnt", retired_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
    endtask

    // One instruction: d1 refused fetch cycles, d2 cycles without response, d3 exec cycles before ex_done.
    task automatic run_instr(input logic [31:0] pc, input logic [31:0] rd,
                             input int d1, input int d2, input int d3,
                             input logic jal, input logic br, input logic c, input logic h);
        bus.pc = pc;
        for (int i = 0; i < d1; i++) begin
            bus.imem_ready  = 1'b0;
            bus.imem_rvalid = 1'($urandom);
            bus.imem_rdata  = $urandom;
            bus.ex_done     = 1'($urandom);
            rand_decode();
            #1;
            chk("stall_req_held", 32'(bus.imem_req), 32'd1);
            chk("stall_addr_stable", bus.imem_addr, pc);
            tick();
        end
        bus.imem_ready  = 1'b1;
        bus.imem_rvalid = 1'($urandom);
        bus.imem_rdata  = $urandom;
        bus.ex_done     = 1'($urandom);
        rand_decode();
        fq.push_back('{32'(cyc), pc});
        tick();
        for (int i = 0; i < d2; i++) begin
            bus.imem_ready  = 1'($urandom);
            bus.imem_rvalid = 1'b0;
            bus.ex_done     = 1'($urandom);
            rand_decode();
            tick();
        end
        bus.imem_ready  = 1'($urandom);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = rd;
        bus.ex_done     = 1'($urandom);
        rand_decode();
        tick();
        for (int i = 0; i < d3; i++) begin
            bus.imem_ready  = 1'($urandom);
            bus.imem_rvalid = 1'($urandom);
            bus.imem_rdata  = $urandom;
            bus.ex_done     = 1'b0;
            rand_decode();
            tick();
        end
        bus.imem_ready  = 1'($urandom);
        bus.imem_rvalid = 1'($urandom);
        bus.imem_rdata  = $urandom;
        bus.ex_done     = 1'b1;
        bus.is_jal      = jal;
        bus.is_branch   = br;
        bus.cmp         = c;
        bus.halt        = h;
        rq.push_back('{32'(cyc), rd, model_sel(jal, br, c)});
        tick();
        bus.ex_done     = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.halt        = 1'b0;
        exp_stall   += d1 + d2;
        exp_retired += 1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.pc          = 32'd0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'd0;
        bus.ex_done     = 1'b0;
        bus.is_jal      = 1'b0;
        bus.is_branch   = 1'b0;
        bus.cmp         = 1'b0;
        bus.halt        = 1'b0;
        tick();
        mon_en = 1'b1;
        do_reset();

        // Back-to-back minimum latency, then the pc_sel priority cases.
        run_instr(32'h40, 32'h1234_5678, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h44, 32'hA000_0001, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr(32'h48, 32'hA000_0002, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr(32'h4C, 32'hA000_0003, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        // imem refuses for 3 cycles and answers 2 cycles late.
        run_instr(32'h50, 32'hA000_0004, 3, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("stall_cnt_after_delay", stall_cnt, exp_cnt(5));
        chk("retired_cnt_after_delay", retired_cnt, exp_cnt(5));

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            run_instr($urandom & 32'hFFFF_FFFC, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'b0);
        end
        #1;
        chk("retired_cnt_random", retired_cnt, exp_cnt(exp_retired));
        chk("stall_cnt_random", stall_cnt, exp_cnt(exp_stall));

        // Reset while waiting for a response; a stray response must not be captured.
        bus.pc          = 32'h100;
        bus.imem_ready  = 1'b1;
        fq.push_back('{32'(cyc), 32'h100});
        tick();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        reset           = 1'b1;
        tick();
        reset           = 1'b0;
        exp_stall       = 0;
        exp_retired     = 0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("midrst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("midrst_instr", bus.instr, 32'd0);
        chk("midrst_refetch_req", 32'(bus.imem_req), 32'd1);
        tick();
        bus.imem_rvalid = 1'b0;
        exp_stall      += 1;
        #1;
        chk("midrst_stray_instr", bus.instr, 32'd0);
        chk("midrst_stray_valid", 32'(bus.instr_valid), 32'd0);
        run_instr(32'h100, 32'hB000_0001, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midrst_stall_cnt", stall_cnt, exp_cnt(exp_stall));

        // Four instructions, the last one halts; afterwards everything is frozen.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_instr(32'h200 + 32'(4 * k), $urandom,
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      1'b0, 1'b1, 1'($urandom), 1'(k == 3));
        end
        #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("halt_retired_cnt", retired_cnt, exp_cnt(4));
        for (int i = 0; i < 8; i++) begin
            bus.imem_ready  = 1'(i % 2);
            bus.ex_done     = 1'((i + 1) % 2);
            bus.imem_rvalid = 1'(i % 2);
            bus.halt        = 1'b0;
            #1;
            chk("halted_req", 32'(bus.imem_req), 32'd0);
            chk("halted_pc_we", 32'(bus.pc_we), 32'd0);
            chk("halted_flag", 32'(halted), 32'd1);
            chk("halted_retired_frozen", retired_cnt, exp_cnt(exp_retired));
            chk("halted_stall_frozen", stall_cnt, exp_cnt(exp_stall));
            tick();
        end
        bus.imem_ready  = 1'b0;
        bus.ex_done     = 1'b0;
        bus.imem_rvalid = 1'b0;

        tick();
        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
        chk("retire_queue_drained", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
